// File: rtl/systolic_array.sv
// systolic_array: weight-parallel ARRAY_SIZE x ARRAY_SIZE MAC array with runtime-selectable
// operand precision (1/2/4/8 bit) and per-operand signedness. One matrix-vector product per
// clock, single registered output stage.
// Optional build macro: PSUM_ACCUM_EN -- psums accumulate (wrapping) instead of overwrite.
module systolic_array #(
    parameter int unsigned ARRAY_SIZE = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3:0]                           in_width,
    input  logic [3:0]                           weight_width,
    input  logic                                 s_in,
    input  logic                                 s_weight,
    input  logic [8*ARRAY_SIZE*ARRAY_SIZE-1:0]   weights,
    input  logic [8*ARRAY_SIZE-1:0]              inputs,
    output logic [32*ARRAY_SIZE-1:0]             psums
);

    // 18-bit products plus enough headroom for ARRAY_SIZE terms
    localparam int unsigned SumW = 18 + $clog2(ARRAY_SIZE);

    // Extract the low P bits of a lane and sign/zero-extend to 9 bits.
    // Width codes other than 1, 2 and 4 fall back to full 8-bit lanes.
    function automatic logic signed [8:0] decode_lane(input logic [7:0] lane,
                                                      input logic [3:0] width,
                                                      input logic       sgn);
        logic [8:0] v;
        case (width)
            4'd1:    v = {{8{sgn & lane[0]}}, lane[0]};
            4'd2:    v = {{7{sgn & lane[1]}}, lane[1:0]};
            4'd4:    v = {{5{sgn & lane[3]}}, lane[3:0]};
            default: v = {sgn & lane[7], lane};
        endcase
        return $signed(v);
    endfunction

    logic signed [8:0]      x_dec    [ARRAY_SIZE];
    logic signed [8:0]      w_dec    [ARRAY_SIZE][ARRAY_SIZE];
    logic signed [17:0]     prod     [ARRAY_SIZE][ARRAY_SIZE];
    logic signed [SumW-1:0] col_sum  [ARRAY_SIZE];
    logic        [31:0]     col_ext  [ARRAY_SIZE];
    logic        [31:0]     psum_q   [ARRAY_SIZE];

    // Decode every activation and weight lane into 9-bit signed operands
    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            x_dec[i] = decode_lane(inputs[i*8 +: 8], in_width, s_in);
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                w_dec[i][j] = decode_lane(weights[(i*ARRAY_SIZE+j)*8 +: 8], weight_width,
                                          s_weight);
            end
        end
    end

    // Exact 9x9 signed products for every array cell
    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                prod[i][j] = 18'(x_dec[i]) * 18'(w_dec[i][j]);
            end
        end
    end

    // Column reduction and extension to 32 bits; unsigned-only sums are never negative,
    // so sign extension covers both cases
    always_comb begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            col_sum[j] = '0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                col_sum[j] = col_sum[j] + {{(SumW-18){prod[i][j][17]}}, prod[i][j]};
            end
            col_ext[j] = {{(32-SumW){col_sum[j][SumW-1]}}, col_sum[j]};
        end
    end

    // Output register: cleared by reset, otherwise loaded (or accumulated) every edge
    always_ff @(posedge clk) begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            if (rst) begin
                psum_q[j] <= '0;
            end else begin
`ifdef PSUM_ACCUM_EN
                psum_q[j] <= psum_q[j] + col_ext[j];
`else
                psum_q[j] <= col_ext[j];
`endif
            end
        end
    end

    // Flatten the column registers onto the output bus
    always_comb begin
        psums = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            psums[j*32 +: 32] = psum_q[j];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed and random stimulus for systolic_array; an arithmetic model
// pushes expected column results into a scoreboard queue, popped after each edge.
module tb_systolic_array;

    localparam int N = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           in_width;
    logic [3:0]           weight_width;
    logic                 s_in;
    logic                 s_weight;
    logic [8*N*N-1:0]     weights;
    logic [8*N-1:0]       inputs;
    logic [32*N-1:0]      psums;

    logic [31:0] sb_q[$];
    logic [31:0] model_acc [N];
    int          n_assert = 0;
    int          n_fail = 0;

    systolic_array #(.ARRAY_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_width     (in_width),
        .weight_width (weight_width),
        .s_in         (s_in),
        .s_weight     (s_weight),
        .weights      (weights),
        .inputs       (inputs),
        .psums        (psums)
    );

    always #5 clk = ~clk;

    // Reference operand decode in plain integer arithmetic
    function automatic longint ref_dec(input logic [7:0] lane, input logic [3:0] wd,
                                       input logic sgn);
        int     p;
        longint v;
        p = (wd == 4'd1) ? 1 : (wd == 4'd2) ? 2 : (wd == 4'd4) ? 4 : 8;
        v = longint'(lane) & ((longint'(1) << p) - 1);
        if (sgn && v >= (longint'(1) << (p - 1))) v = v - (longint'(1) << p);
        return v;
    endfunction

    task automatic set_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                           input logic sw);
        in_width = iw; weight_width = ww; s_in = si; s_weight = sw;
    endtask

    task automatic set_x(input logic [7:0] v);
        for (int i = 0; i < N; i++) inputs[i*8 +: 8] = v;
    endtask

    task automatic set_x_ramp();
        for (int i = 0; i < N; i++) inputs[i*8 +: 8] = 8'(i + 1);
    endtask

    task automatic set_w(input logic [7:0] v);
        for (int k = 0; k < N*N; k++) weights[k*8 +: 8] = v;
    endtask

    task automatic set_w_col();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) weights[(i*N+j)*8 +: 8] = 8'(j);
    endtask

    task automatic set_random();
        logic [3:0] codes [6];
        codes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};
        set_cfg(codes[$urandom_range(5)], codes[$urandom_range(5)], 1'($urandom),
                1'($urandom));
        for (int i = 0; i < N; i++) inputs[i*8 +: 8] = 8'($urandom);
        for (int k = 0; k < N*N; k++) weights[k*8 +: 8] = 8'($urandom);
    endtask

    // Push expected results for the current inputs, clock once, pop and compare
    task automatic step(input string tag);
        longint      dot;
        logic [31:0] exp_v;
        logic [31:0] obs_v;
        for (int j = 0; j < N; j++) begin
            dot = 0;
            for (int i = 0; i < N; i++) begin
                dot += ref_dec(inputs[i*8 +: 8], in_width, s_in) *
                       ref_dec(weights[(i*N+j)*8 +: 8], weight_width, s_weight);
            end
            if (rst) model_acc[j] = '0;
`ifdef PSUM_ACCUM_EN
            else model_acc[j] = model_acc[j] + 32'(dot);
`else
            else model_acc[j] = 32'(dot);
`endif
            sb_q.push_back(model_acc[j]);
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            exp_v = sb_q.pop_front();
            obs_v = psums[j*32 +: 32];
            n_assert++;
            assert (obs_v === exp_v) else begin
                n_fail++;
                $error("FAIL %s col%0d observed=%h expected=%h", tag, j, obs_v, exp_v);
            end
        end
    endtask

    // psums must be stable between edges even while inputs change
    task automatic check_hold(input string tag);
        set_random();
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            n_assert++;
            assert (psums[j*32 +: 32] === model_acc[j]) else begin
                n_fail++;
                $error("FAIL %s col%0d observed=%h expected=%h", tag, j, psums[j*32 +: 32],
                       model_acc[j]);
            end
        end
    endtask

    initial begin
        // Reset held with nonzero operands, then released with zero operands
        rst = 1'b1;
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
        set_x(8'h5A);
        set_w(8'hC3);
        repeat (3) step("reset");
        rst = 1'b0;
        set_x(8'h00);
        set_w(8'h00);
        step("reset_release_zero");

        // 8-bit unsigned
        set_x_ramp();
        set_w(8'h01);
        step("u8_ones");
        set_w_col();
        step("u8_colidx");
        check_hold("hold");

        // 8-bit signed and mixed signedness
        set_cfg(4'd8, 4'd8, 1'b1, 1'b1);
        set_x(8'hFF);
        set_w(8'h80);
        step("s8_neg_x_neg");
        s_weight = 1'b0;
        step("s8_signed_x_unsigned");

        // 1-bit mode, upper lane bits ignored
        set_cfg(4'd1, 4'd1, 1'b0, 1'b0);
        set_x(8'hFF);
        set_w(8'hFE);
        step("w1_upper_ignored");
        set_w(8'h01);
        step("w1_ones");
        s_in = 1'b1;
        step("w1_signed_in");

        // 4-bit signed inputs against 2-bit unsigned weights, then illegal width code
        set_cfg(4'd4, 4'd2, 1'b1, 1'b0);
        set_x(8'h0F);
        set_w(8'h03);
        step("w4s_w2u");
        set_cfg(4'd3, 4'd2, 1'b0, 1'b0);
        step("w3_as_8bit");

        // Back-to-back random operands with a single-cycle reset in the middle
        for (int k = 0; k < 12; k++) begin
            set_random();
            step("b2b");
        end
        rst = 1'b1;
        set_random();
        step("midrun_reset");
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            set_random();
            step("b2b_after_reset");
        end

        // All-ones 8-bit unsigned held three cycles after a reset
        rst = 1'b1;
        step("pre_ones_reset");
        rst = 1'b0;
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
        set_x(8'hFF);
        set_w(8'hFF);
        repeat (3) step("u8_all_ones_held");

        n_assert++;
        assert (sb_q.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- Weight-parallel ARRAY_SIZE x ARRAY_SIZE multiply-accumulate array with Bit-Fusion-style runtime-selectable operand precision (1/2/4/8 bit) and per-operand signedness.
- Computes one matrix-vector product per clock: a vector of ARRAY_SIZE input activations against an ARRAY_SIZE x ARRAY_SIZE weight matrix.
- Produces ARRAY_SIZE 32-bit partial sums, one per column.
- Sits between the activation/weight buffers and the accumulation/output stage of the accelerator datapath.

Parameters:
- ARRAY_SIZE, 8, number of rows (inputs) and columns (psums); legal range 2..16.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_width  input  4  input operand precision in bits
- weight_width  input  4  weight operand precision in bits
- s_in  input  1  1 = inputs are two's-complement signed, 0 = unsigned
- s_weight  input  1  1 = weights are two's-complement signed, 0 = unsigned
- weights  input  8*ARRAY_SIZE*ARRAY_SIZE  weight matrix; w[i][j] = weights[(i*ARRAY_SIZE+j)*8 +: 8]; row i = input index, column j = output index
- inputs  input  8*ARRAY_SIZE  activation vector; x[i] = inputs[i*8 +: 8]
- psums  output  32*ARRAY_SIZE  column results; psum[j] = psums[j*32 +: 32]

Behaviour:
- Reset:
  - rst=1 at a rising edge sets every psum to 0 on that edge.
  - Reset overrides any computation in flight; the cycle after rst deasserts computes normally from the inputs then present.
- Operand decode, per 8-bit lane:
  - Precision P from the width field: 1, 2 or 4 selects that precision; 8 and every other code (0, 3, 5..15) select 8-bit.
  - Only the low P bits of the lane are used; the upper bits are ignored.
  - Signed flag = 1: the lane is sign-extended from bit P-1. A 1-bit signed operand of 1 equals -1.
  - Signed flag = 0: the lane is zero-extended.
  - in_width/s_in apply to all inputs; weight_width/s_weight apply to all weights. Input and weight settings are independent.
- Arithmetic:
  - Product p[i][j] = x[i]*w[i][j], computed exactly as a signed 18-bit value. Decoded operands are 9-bit signed.
  - psum[j] = sum over i of p[i][j], computed exactly, then sign-extended (or zero-extended if both operands are unsigned) to 32 bits.
  - No overflow is possible for ARRAY_SIZE <= 16.
- Timing:
  - Single registered stage. All inputs, including width and sign controls, are sampled at rising edge N.
  - Results are visible on psums immediately after edge N; latency is 1 cycle.
  - Throughput is one full matrix-vector product per cycle.
  - psums hold their value between edges.
- Controls are not persistent state: changing the width or sign inputs affects only the edges at which the new value is sampled. There is no mid-stream reconfiguration hazard.
- No handshake. Every non-reset edge updates psums.

Optional Feature:
- Macro: PSUM_ACCUM_EN.
- Defined:
  - At each non-reset edge, psum[j] <= psum[j] + (column dot product), wrapping modulo 2^32.
  - rst clears all accumulators to 0.
  - This is the only way to clear them.
- Undefined: psum[j] <= column dot product (overwrite), as specified above.

Test Plan:
- Reset: rst=1 for 3 cycles with nonzero operands -> all psums = 0. Release rst with all-zero operands -> psums stay 0.
- 8-bit unsigned:
  - Stimulus: widths=8, signs=0, x[i]=i+1, w[i][j]=1 for all i,j.
  - Required: after 1 edge, every psum = 36 (ARRAY_SIZE=8).
  - Then set w[i][j]=j -> psum[j] = 36*j.
- 8-bit signed:
  - Stimulus: s_in=s_weight=1, x[i]=0xFF (-1), w[i][j]=0x80 (-128).
  - Required: every psum = 1024.
  - Then s_weight=0 -> every psum = -1024 = 0xFFFFFC00.
- 1-bit mode:
  - Stimulus: widths=1, signs=0, x[i]=0xFF, w[i][j]=0xFE.
  - Required: psum = 0 (upper bits ignored).
  - Then w[i][j]=0x01 -> psum = 8.
  - Then s_in=1 -> psum = -8.
- 4-bit/2-bit mixed:
  - Stimulus: in_width=4 (signed), weight_width=2 (unsigned), x[i]=0x0F (-1), w[i][j]=0x03 (3).
  - Required: every psum = -24 = 0xFFFFFFE8.
  - in_width=3 -> treated as 8-bit unsigned: x=15, psum = 360.
- Back-to-back and reset mid-run:
  - Stimulus: change operands every cycle.
  - Required: each psum equals the product of the previous edge's operands.
  - Assert rst for one cycle mid-stream -> psums 0 that cycle, correct results resume next cycle.
  - With PSUM_ACCUM_EN: the same stimulus held 3 cycles from 8-bit unsigned all-ones (x[i]=w[i][j]=0xFF) -> psum = 3*8*65025 = 1560600.
